// File: rtl/uart_frame_parser.sv
// uart_frame_parser: delimits SYNC/LEN/payload/CHECKSUM frames arriving from a
// UART byte receiver, buffers good payloads and replays them over a valid/ready
// byte stream. Bad frames and bytes that arrive while draining are dropped and
// reported through frame_err/err_code.
module uart_frame_parser #(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  widx_q, widx_d;
    logic [7:0]  ridx_q, ridx_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        rx_valid_q;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        wr_en;
    logic [7:0]  payload_q [MAX_LEN];

    logic strb;
    logic in_frame;
    logic timeout_hit;

    // The receiver's valid is a level; only its rising edge marks a new byte.
    assign strb        = rx_valid & ~rx_valid_q;
    assign in_frame    = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign timeout_hit = in_frame && !strb && (tcnt_q == TIMEOUT_CYCLES - 16'd1);

    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = payload_q[ridx_q[IDX_W-1:0]];
    assign out_last  = out_valid && (ridx_q == len_q - 8'd1);
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != S_IDLE);

    // Next-state and pulse decode for the frame FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        widx_d      = widx_q;
        ridx_d      = ridx_q;
        tcnt_d      = '0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        wr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (strb && rx_data == SYNC_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (strb) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = S_IDLE;
                    end else begin
                        len_d   = rx_data;
                        sum_d   = rx_data;
                        widx_d  = 8'd0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (strb) begin
                    wr_en  = 1'b1;
                    sum_d  = sum_q + rx_data;
                    widx_d = widx_q + 8'd1;
                    if (widx_q == len_q - 8'd1) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (strb) begin
                    if (rx_data == sum_q) begin
                        frame_ok_d = 1'b1;
                        ridx_d     = 8'd0;
                        state_d    = S_DRAIN;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    ridx_d = ridx_q + 8'd1;
                    if (out_last) state_d = S_IDLE;
                end
                // The buffer is busy replaying; a new byte has nowhere to go.
                if (strb) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte watchdog, only while a frame is being received.
        if (in_frame) begin
            if (!strb) tcnt_d = tcnt_q + 16'd1;
            if (timeout_hit) begin
                frame_err_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
                tcnt_d      = '0;
                state_d     = S_IDLE;
            end
        end
    end

    // State, counters and registered status pulses.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            sum_q       <= '0;
            widx_q      <= '0;
            ridx_q      <= '0;
            tcnt_q      <= '0;
            rx_valid_q  <= 1'b1;  // a level already high at release is not a new byte
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_TIMEOUT;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            widx_q      <= widx_d;
            ridx_q      <= ridx_d;
            tcnt_q      <= tcnt_d;
            rx_valid_q  <= rx_valid;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload buffer write port.
    always_ff @(posedge Clk) begin
        // NOTE: the buffer has no reset; its contents are only read after being written by a frame.
        if (wr_en) payload_q[widx_q[IDX_W-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good frames, checksum/length/timeout
// errors, backpressure with overrun, reset abort and valid-level edge detection.
module tb_uart_frame_parser;

    logic       Clk;
    logic       Rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    logic rdy_level;
    logic rdy_mode;
    int   rcnt;

    assign out_ready = rdy_mode ? (rcnt == 0) : rdy_level;

    uart_frame_parser #(
        .MAX_LEN       (16),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(16'd100)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code),
        .busy     (busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int strb_cyc = 0;
    int ok_cnt = 0, err_cnt = 0, ok_cyc = -1, err_cyc = -1;
    int both_cnt = 0, valid_cnt = 0, stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_last  = 1'b0;
    logic [7:0] q_data [$];
    logic       q_last [$];
    int         q_cyc  [$];

    always @(posedge Clk) cyc <= cyc + 1;

    // Consumer readiness pattern: ready one cycle in three when rdy_mode is set.
    always begin
        @(posedge Clk);
        #1;
        rcnt = (rcnt + 1) % 3;
    end

    // Output observer, sampled on the falling edge.
    always @(negedge Clk) begin
        if (frame_ok) begin ok_cnt++; ok_cyc = cyc; end
        if (frame_err) begin err_cnt++; err_cyc = cyc; end
        if (frame_ok && frame_err) both_cnt++;
        if (out_valid) valid_cnt++;
        if (prev_stall && (!out_valid || out_data != prev_data || out_last != prev_last)) stall_viol++;
        if (out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One received byte: valid rises, stays high two cycles, then drops.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        strb_cyc = cyc;
        step();
        rx_valid = 1'b0;
        step();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) step();
        check(tag, busy, 1'b0);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic check_drain(input string tag, input logic [7:0] exp[$]);
        check({tag, " count"}, q_data.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < q_data.size()) begin
                check($sformatf("%s data[%0d]", tag, i), q_data[i], exp[i]);
                check($sformatf("%s last[%0d]", tag, i), q_last[i], (i == exp.size() - 1));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok0, err0, v0, s;
        logic [7:0] exp_q [$];

        Rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rdy_level = 1'b1;
        rdy_mode  = 1'b0;
        rcnt      = 0;

        repeat (3) step();
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_last", out_last, 1'b0);
        check("rst frame_ok", frame_ok, 1'b0);
        check("rst frame_err", frame_err, 1'b0);
        check("rst err_code", err_code, 2'd0);
        check("rst busy", busy, 1'b0);
        Rst_n = 1'b1;
        step();
        step();

        // Good frame, always-ready consumer.
        clear_q();
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'hA5);
        check("good busy after sync", busy, 1'b1);
        send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h69);
        s = strb_cyc;
        wait_idle("good idle");
        check("good ok pulses", ok_cnt - ok0, 1);
        check("good no err", err_cnt - err0, 0);
        check("good ok cycle", ok_cyc, s);
        exp_q = '{8'h11, 8'h22, 8'h33};
        check_drain("good", exp_q);
        if (q_cyc.size() == 3) begin
            check("good valid with ok", q_cyc[0], s);
            check("good consecutive", q_cyc[2] - q_cyc[0], 2);
        end

        // Checksum error, then a good frame.
        clear_q();
        ok0 = ok_cnt; err0 = err_cnt; v0 = valid_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20);
        send_byte(8'h31);
        s = strb_cyc;
        check("csum err pulses", err_cnt - err0, 1);
        check("csum err cycle", err_cyc, s);
        check("csum err_code", err_code, 2'd2);
        check("csum no valid", valid_cnt - v0, 0);
        check("csum no ok", ok_cnt - ok0, 0);
        check("csum idle", busy, 1'b0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        wait_idle("after csum idle");
        check("after csum ok", ok_cnt - ok0, 1);
        exp_q = '{8'h7F};
        check_drain("after csum", exp_q);

        // Length above MAX_LEN.
        err0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h11);
        s = strb_cyc;
        check("len17 err", err_cnt - err0, 1);
        check("len17 err cycle", err_cyc, s);
        check("len17 err_code", err_code, 2'd1);
        check("len17 idle", busy, 1'b0);

        // Inter-byte timeout.
        err0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        s = strb_cyc;
        for (int i = 0; i < 300 && err_cnt == err0; i++) step();
        check("timeout err", err_cnt - err0, 1);
        check("timeout cycle", err_cyc, s + 100);
        check("timeout err_code", err_code, 2'd0);
        check("timeout idle", busy, 1'b0);

        // Zero length.
        err0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h00);
        s = strb_cyc;
        check("len0 err", err_cnt - err0, 1);
        check("len0 err cycle", err_cyc, s);
        check("len0 err_code", err_code, 2'd1);
        check("len0 idle", busy, 1'b0);

        // Byte lands exactly on the timeout cycle: strobe wins.
        clear_q();
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        s = strb_cyc;
        while (cyc < s + 99) step();
        send_byte(8'h20);
        check("edge strobe cycle", strb_cyc, s + 100);
        check("edge no timeout", err_cnt - err0, 0);
        send_byte(8'h32);
        wait_idle("edge idle");
        check("edge ok", ok_cnt - ok0, 1);
        exp_q = '{8'h10, 8'h20};
        check_drain("edge", exp_q);

        // Backpressure plus overrun bytes during drain.
        clear_q();
        rdy_mode = 1'b1;
        ok0 = ok_cnt; err0 = err_cnt; stall_viol = 0;
        send_byte(8'hA5); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0E);
        send_byte(8'hA5);
        send_byte(8'h55);
        check("ovr err pulses", err_cnt - err0, 2);
        check("ovr err_code", err_code, 2'd3);
        wait_idle("ovr idle");
        check("ovr ok", ok_cnt - ok0, 1);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_drain("bp", exp_q);
        check("bp stall stable", stall_viol, 0);
        send_byte(8'h05);
        check("ovr sync dropped", busy, 1'b0);
        check("ovr no extra err", err_cnt - err0, 2);
        rdy_mode = 1'b0;

        // Reset mid-payload.
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        check("mid busy", busy, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("mid rst busy", busy, 1'b0);
        check("mid rst out_valid", out_valid, 1'b0);
        check("mid rst frame_err", frame_err, 1'b0);
        check("mid rst err_code", err_code, 2'd0);

        // Valid level held high across reset release.
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        step();
        step();
        err0 = err_cnt; ok0 = ok_cnt;
        Rst_n = 1'b1;
        repeat (3) step();
        check("held valid no strobe", busy, 1'b0);
        rx_valid = 1'b0;
        step();

        // Junk before sync, then a good frame.
        clear_q();
        send_byte(8'h00); send_byte(8'hFF);
        check("junk idle", busy, 1'b0);
        check("junk no err", err_cnt - err0, 0);
        send_byte(8'hA5);
        check("post junk sync", busy, 1'b1);
        send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
        wait_idle("post junk idle");
        check("post junk ok", ok_cnt - ok0, 1);
        exp_q = '{8'h42};
        check_drain("post junk", exp_q);

        check("ok and err never together", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Sits directly downstream of the UART byte receiver. Consumes its byte output and level-style valid flag, and delimits framed packets: SYNC, LEN, LEN payload bytes, then CHECKSUM. Good frames are buffered and replayed to the processing logic over a valid/ready byte stream. Bad frames are dropped and reported with an error code.

Parameters:
MAX_LEN, 16, maximum payload length in bytes (1..255); sets the internal buffer depth.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 16'd50000, maximum idle Clk cycles between bytes inside a frame.

Ports:
Clk  input  1  system clock, rising edge.
Rst_n  input  1  asynchronous active-low reset.
rx_data  input  8  received byte from the UART receiver.
rx_valid  input  1  receiver valid level: rises when a byte completes, stays high until the next start bit.
out_data  output  8  payload byte presented to the consumer.
out_valid  output  1  out_data holds a payload byte.
out_ready  input  1  consumer accepts the byte this cycle.
out_last  output  1  the current out_data is the final payload byte.
frame_ok  output  1  one-cycle pulse: frame passed its checksum.
frame_err  output  1  one-cycle pulse: frame or byte was discarded.
err_code  output  2  cause of the last error (0 timeout, 1 bad length, 2 checksum, 3 overrun); held until the next error.
busy  output  1  state is not IDLE.

Behaviour:
- Reset: one clock, Clk; reset is asynchronous and active-low on Rst_n.
- Reset values: state IDLE; out_valid, out_last, frame_ok, frame_err, busy = 0; err_code = 0; counters = 0.
- Reset values, continued: rx_valid_d = 1, so an rx_valid level already high at reset release is not taken as a byte.
- Buffer contents are not reset; they are don't-care.
- Mid-operation reset aborts any frame immediately.
- Byte strobe: strb = rx_valid & ~rx_valid_d, with rx_valid_d registered every cycle. Exactly one strobe is produced per received byte.
- Response latency: all state and output effects of a strobe are visible on the edge that samples the rising rx_valid, i.e. one cycle later.
- IDLE: on strb with rx_data == SYNC_BYTE, go to LEN. Any other byte is silently ignored, with no error.
- LEN: on strb, if rx_data == 0 or rx_data > MAX_LEN: frame_err, err_code = 1, go to IDLE.
- LEN, valid length: len = rx_data; sum = rx_data; widx = 0; go to PAYLOAD.
- PAYLOAD: on strb, buf[widx] = rx_data; sum = sum + rx_data (8-bit, wraps mod 256); widx + 1.
- PAYLOAD exit: after the byte with widx == len-1 is stored, go to CHECK.
- CHECK: on strb, if rx_data == sum: frame_ok pulse; ridx = 0; go to DRAIN.
- CHECK mismatch: frame_err, err_code = 2, go to IDLE.
- Timeout: in LEN, PAYLOAD and CHECK, tcnt clears on every strb and otherwise increments.
- Timeout expiry: when tcnt reaches TIMEOUT_CYCLES-1 with no strb: frame_err, err_code = 0, go to IDLE.
- Timeout vs. strobe in the same cycle: strb wins and the timeout does not fire.
- tcnt holds at 0 in IDLE and DRAIN.
- DRAIN outputs: out_valid = 1; out_data = buf[ridx]; out_last = (ridx == len-1).
- DRAIN handshake: a transfer occurs when out_valid & out_ready. On a transfer ridx + 1; after the last transfer, out_valid = 0 and state goes to IDLE the next cycle.
- DRAIN stalls: out_data and out_last are stable while out_valid & ~out_ready. out_valid is never withdrawn before acceptance.
- DRAIN timing: out_valid rises in the same cycle as the frame_ok pulse.
- Overrun: a strb during DRAIN drops that byte and raises frame_err with err_code = 3. Draining continues unaffected.
- Overrun limit: a SYNC byte arriving during DRAIN is also dropped; the next frame needs a fresh SYNC after IDLE.
- frame_ok and frame_err are never high in the same cycle, except an overrun on the frame_ok cycle, which is impossible because the strobes are ≥1 byte apart.
- busy = (state != IDLE).

Test Plan:
- Good frame: rx bytes A5, 03, 11, 22, 33, 69 (sum 03+11+22+33 = 69), out_ready = 1 → frame_ok pulse once; out_data 11, 22, 33 on consecutive cycles; out_last only with 33; busy then falls.
- Checksum error: A5, 02, 10, 20, 31 → frame_err, err_code = 2, no out_valid. A following good frame is still accepted.
- Bad length: A5, 00 → err_code = 1. A5, MAX_LEN+1 → err_code = 1. Both return to IDLE immediately.
- Timeout: TIMEOUT_CYCLES = 100; A5, 02, 10, then silence → frame_err with err_code = 0 exactly 100 cycles after the last strobe. A byte landing exactly on that cycle prevents the error.
- Backpressure and overrun: good 4-byte frame with out_ready toggled 0/1 → no byte lost or duplicated; out_data stable while stalled. A byte injected during DRAIN → err_code = 3 and drain output unchanged.
- Reset and edge detection: Rst_n low mid-PAYLOAD → outputs zero at once, no out_valid. rx_valid held high across reset release → no strobe. Junk bytes 00, FF before A5 → ignored without error.
